// File: rtl/ble_link_supervisor.sv
// Link supervisor between the BLE vector parser and the balance/PID loop:
// arming FSM, link-loss watchdog, setpoint ramping and sample-aligned gain commit.
module ble_link_supervisor #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned TIMEOUT_MS = 500,
    parameter int unsigned RAMP_DIV   = 100_000,
    parameter int unsigned RAMP_STEP  = 1,
    parameter int unsigned MAX_GAIN   = 200,
    parameter logic [7:0]  ARM_CODE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vector_valid,
    input  logic [7:0]  initialize_mpu_motor,
    input  logic [7:0]  initialize_mpu,
    input  logic [7:0]  ble_set_pitch,
    input  logic [7:0]  ble_set_yaw,
    input  logic [7:0]  ble_pitch_kP,
    input  logic [7:0]  ble_pitch_kI,
    input  logic [7:0]  ble_pitch_kD,
    input  logic [7:0]  ble_yaw_kP,
    input  logic [7:0]  ble_yaw_kI,
    input  logic [7:0]  ble_yaw_kD,
    input  logic        ctrl_sample,
    output logic [7:0]  set_pitch,
    output logic [7:0]  set_yaw,
    output logic [7:0]  pitch_kP,
    output logic [7:0]  pitch_kI,
    output logic [7:0]  pitch_kD,
    output logic [7:0]  yaw_kP,
    output logic [7:0]  yaw_kI,
    output logic [7:0]  yaw_kD,
    output logic        gains_updated,
    output logic        mpu_init_pulse,
    output logic        motor_en,
    output logic [1:0]  link_state,
    output logic        failsafe,
    output logic [15:0] frame_count
);

    localparam int unsigned   TIMEOUT_CYCLES = (CLK_FREQ / 1000) * TIMEOUT_MS;
    localparam logic [31:0]   TO_LIMIT       = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0]   TO_LAST        = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   DIV_LAST       = 32'(RAMP_DIV - 1);
    localparam logic signed [8:0] STEP       = 9'(RAMP_STEP);
    localparam logic [7:0]    GAIN_MAX       = 8'(MAX_GAIN);

    typedef enum logic [1:0] {
        ST_NO_LINK  = 2'd0,
        ST_DISARMED = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_motor_en;
    logic            r_failsafe;
    logic [31:0]     r_wd_cnt;
    logic [31:0]     r_div;
    logic [7:0]      r_prev_arm;
    logic [7:0]      r_prev_mpu;
    logic            r_mpu_pulse;
    logic [15:0]     r_frame_count;
    logic [7:0]      r_tgt_pitch;
    logic [7:0]      r_tgt_yaw;
    logic [7:0]      r_set_pitch;
    logic [7:0]      r_set_yaw;
    logic [5:0][7:0] r_shadow;
    logic [5:0][7:0] r_gain;
    logic            r_gains_upd;

    logic            w_timeout;
    logic            w_tick;
    logic            w_arm_req;
    logic [5:0][7:0] w_frame_gains;

    assign w_timeout     = !vector_valid && (r_wd_cnt == TO_LAST);
    assign w_tick        = (r_div == DIV_LAST);
    assign w_arm_req     = (initialize_mpu_motor == ARM_CODE);
    assign w_frame_gains = {ble_yaw_kD, ble_yaw_kI, ble_yaw_kP,
                            ble_pitch_kD, ble_pitch_kI, ble_pitch_kP};

    function automatic logic [7:0] f_sat(input logic [7:0] v);
        f_sat = (v > GAIN_MAX) ? GAIN_MAX : v;
    endfunction

    // One ramp step toward the target, computed 9-bit signed so extremes never wrap.
    function automatic logic [7:0] f_ramp(input logic [7:0] cur, input logic [7:0] tgt);
        logic signed [8:0] cur_s;
        logic signed [8:0] diff;
        cur_s = $signed({cur[7], cur});
        diff  = $signed({tgt[7], tgt}) - cur_s;
        if (diff > STEP)
            f_ramp = 8'(cur_s + STEP);
        else if (diff < -STEP)
            f_ramp = 8'(cur_s - STEP);
        else
            f_ramp = tgt;
    endfunction

    // Link/arm state machine with registered motor_en and failsafe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_NO_LINK;
            r_motor_en <= 1'b0;
            r_failsafe <= 1'b0;
        end else begin
            unique case (r_state)
                ST_NO_LINK: begin
                    if (vector_valid) r_state <= ST_DISARMED;
                end
                ST_DISARMED: begin
                    if (vector_valid) begin
                        if (w_arm_req && (r_prev_arm != ARM_CODE)) begin
                            r_state    <= ST_ARMED;
                            r_motor_en <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_NO_LINK;
                    end
                end
                ST_ARMED: begin
                    if (vector_valid) begin
                        if (!w_arm_req) begin
                            r_state    <= ST_DISARMED;
                            r_motor_en <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state    <= ST_FAILSAFE;
                        r_motor_en <= 1'b0;
                        r_failsafe <= 1'b1;
                    end
                end
                ST_FAILSAFE: begin
                    if (vector_valid && !w_arm_req) begin
                        r_state    <= ST_DISARMED;
                        r_failsafe <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Watchdog saturates at the limit so the timeout fires only once per silence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wd_cnt <= 32'd0;
        else if (vector_valid)
            r_wd_cnt <= 32'd0;
        else if (r_wd_cnt != TO_LIMIT)
            r_wd_cnt <= r_wd_cnt + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_count <= 16'd0;
            r_prev_arm    <= 8'd0;
            r_prev_mpu    <= 8'd0;
            r_mpu_pulse   <= 1'b0;
            r_shadow      <= '0;
            r_tgt_pitch   <= 8'd0;
            r_tgt_yaw     <= 8'd0;
        end else begin
            r_mpu_pulse <= vector_valid && (initialize_mpu != 8'd0) && (r_prev_mpu == 8'd0);
            if (vector_valid) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_prev_arm    <= initialize_mpu_motor;
                r_prev_mpu    <= initialize_mpu;
                for (int i = 0; i < 6; i++)
                    r_shadow[i] <= f_sat(w_frame_gains[i]);
            end
            // Targets stay zero in failsafe; a timeout only ever enters NO_LINK or FAILSAFE.
            if (vector_valid && (r_state != ST_FAILSAFE)) begin
                r_tgt_pitch <= ble_set_pitch;
                r_tgt_yaw   <= ble_set_yaw;
            end else if (w_timeout) begin
                r_tgt_pitch <= 8'd0;
                r_tgt_yaw   <= 8'd0;
            end
        end
    end

    // Commit all six gains atomically; a coincident frame lands next sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain      <= '0;
            r_gains_upd <= 1'b0;
        end else if (ctrl_sample && (r_shadow != r_gain)) begin
            r_gain      <= r_shadow;
            r_gains_upd <= 1'b1;
        end else begin
            r_gains_upd <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= 32'd0;
            r_set_pitch <= 8'd0;
            r_set_yaw   <= 8'd0;
        end else begin
            r_div <= w_tick ? 32'd0 : r_div + 32'd1;
            if (w_tick) begin
                r_set_pitch <= f_ramp(r_set_pitch, r_tgt_pitch);
                r_set_yaw   <= f_ramp(r_set_yaw, r_tgt_yaw);
            end
        end
    end

    assign set_pitch      = r_set_pitch;
    assign set_yaw        = r_set_yaw;
    assign pitch_kP       = r_gain[0];
    assign pitch_kI       = r_gain[1];
    assign pitch_kD       = r_gain[2];
    assign yaw_kP         = r_gain[3];
    assign yaw_kI         = r_gain[4];
    assign yaw_kD         = r_gain[5];
    assign gains_updated  = r_gains_upd;
    assign mpu_init_pulse = r_mpu_pulse;
    assign motor_en       = r_motor_en;
    assign link_state     = r_state;
    assign failsafe       = r_failsafe;
    assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_ble_link_supervisor.sv
// Bench for ble_link_supervisor: directed scenarios plus random traffic, all
// outputs compared every cycle against an arithmetic reference model.
module tb_ble_link_supervisor;

    localparam int TO   = 1000;
    localparam int RD   = 4;
    localparam int STP  = 2;
    localparam int GMAX = 200;
    localparam int ARM  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        vv = 1'b0;
    logic        cs = 1'b0;
    logic [7:0]  motor_in = 8'd0;
    logic [7:0]  mpu_in = 8'd0;
    logic [7:0]  sp_in = 8'd0;
    logic [7:0]  sy_in = 8'd0;
    logic [7:0]  g_in [6];

    logic [7:0]  set_pitch, set_yaw;
    logic [7:0]  pitch_kP, pitch_kI, pitch_kD, yaw_kP, yaw_kI, yaw_kD;
    logic        gains_updated, mpu_init_pulse, motor_en, failsafe;
    logic [1:0]  link_state;
    logic [15:0] frame_count;
    logic [47:0] dut_gains;

    assign dut_gains = {yaw_kD, yaw_kI, yaw_kP, pitch_kD, pitch_kI, pitch_kP};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (plain integers, signed setpoints).
    int m_state, m_idle, m_div, m_fc, m_prev_arm, m_prev_mpu;
    int m_tp, m_ty, m_p, m_y;
    int m_sh [6];
    int m_cm [6];
    bit m_gu, m_mp;

    ble_link_supervisor #(
        .CLK_FREQ(1_000_000), .TIMEOUT_MS(1), .RAMP_DIV(RD), .RAMP_STEP(STP),
        .MAX_GAIN(GMAX), .ARM_CODE(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vector_valid(vv),
        .initialize_mpu_motor(motor_in), .initialize_mpu(mpu_in),
        .ble_set_pitch(sp_in), .ble_set_yaw(sy_in),
        .ble_pitch_kP(g_in[0]), .ble_pitch_kI(g_in[1]), .ble_pitch_kD(g_in[2]),
        .ble_yaw_kP(g_in[3]), .ble_yaw_kI(g_in[4]), .ble_yaw_kD(g_in[5]),
        .ctrl_sample(cs),
        .set_pitch(set_pitch), .set_yaw(set_yaw),
        .pitch_kP(pitch_kP), .pitch_kI(pitch_kI), .pitch_kD(pitch_kD),
        .yaw_kP(yaw_kP), .yaw_kI(yaw_kI), .yaw_kD(yaw_kD),
        .gains_updated(gains_updated), .mpu_init_pulse(mpu_init_pulse),
        .motor_en(motor_en), .link_state(link_state), .failsafe(failsafe),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ramp_to(input int cur, input int tgt);
        if (tgt - cur > STP) return cur + STP;
        if (cur - tgt > STP) return cur - STP;
        return tgt;
    endfunction

    function automatic logic [47:0] model_gains();
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[i*8 +: 8] = m_cm[i][7:0];
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_idle = 0; m_div = 0; m_fc = 0; m_prev_arm = 0; m_prev_mpu = 0;
        m_tp = 0; m_ty = 0; m_p = 0; m_y = 0; m_gu = 0; m_mp = 0;
        for (int i = 0; i < 6; i++) begin m_sh[i] = 0; m_cm[i] = 0; end
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        bit frame, expire, differ;
        int ns, mot;
        if (!rst_n) begin model_reset(); return; end
        frame  = vv;
        mot    = int'(motor_in);
        expire = !frame && (m_idle + 1 == TO);
        if (m_div == RD - 1) begin
            m_p = ramp_to(m_p, m_tp);
            m_y = ramp_to(m_y, m_ty);
        end
        m_div = (m_div + 1) % RD;
        differ = 0;
        for (int i = 0; i < 6; i++) if (m_sh[i] != m_cm[i]) differ = 1;
        m_gu = cs && differ;
        if (m_gu) for (int i = 0; i < 6; i++) m_cm[i] = m_sh[i];
        m_mp = frame && (mpu_in != 0) && (m_prev_mpu == 0);
        ns = m_state;
        if (frame) begin
            if (m_state == 0) ns = 1;
            else if (mot != ARM) ns = 1;
            else if (m_state == 1 && m_prev_arm != ARM) ns = 2;
        end else if (expire) begin
            ns = (m_state == 2) ? 3 : ((m_state == 1) ? 0 : m_state);
        end
        if (frame && m_state != 3) begin
            m_tp = $signed(sp_in);
            m_ty = $signed(sy_in);
        end
        if (ns != m_state && (ns == 0 || ns == 3)) begin m_tp = 0; m_ty = 0; end
        m_state = ns;
        m_idle  = frame ? 0 : ((m_idle < TO) ? m_idle + 1 : TO);
        if (frame) begin
            m_fc = (m_fc + 1) % 65536;
            m_prev_arm = mot;
            m_prev_mpu = int'(mpu_in);
            for (int i = 0; i < 6; i++) m_sh[i] = (g_in[i] > GMAX) ? GMAX : int'(g_in[i]);
        end
    endtask

    task automatic check_outputs();
        chk("link_state", 64'(link_state), 64'(m_state));
        chk("motor_en", 64'(motor_en), 64'(m_state == 2));
        chk("failsafe", 64'(failsafe), 64'(m_state == 3));
        chk("set_pitch", 64'(set_pitch), 64'(m_p & 255));
        chk("set_yaw", 64'(set_yaw), 64'(m_y & 255));
        chk("gains", 64'(dut_gains), 64'(model_gains()));
        chk("gains_updated", 64'(gains_updated), 64'(m_gu));
        chk("mpu_init_pulse", 64'(mpu_init_pulse), 64'(m_mp));
        chk("frame_count", 64'(frame_count), 64'(m_fc));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
        vv = 1'b0;
        cs = 1'b0;
    endtask

    task automatic frame(input logic [7:0] mot, input logic [7:0] mpu_b,
                         input logic [7:0] sp, input logic [7:0] sy);
        motor_in = mot; mpu_in = mpu_b; sp_in = sp; sy_in = sy; vv = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, 64'(link_state), 64'd0);
        chk({tag, "_motor_en"}, 64'(motor_en), 64'd0);
        chk({tag, "_setpoints"}, 64'({set_pitch, set_yaw}), 64'd0);
        chk({tag, "_gains"}, 64'(dut_gains), 64'd0);
        chk({tag, "_flags"}, 64'({failsafe, gains_updated, mpu_init_pulse}), 64'd0);
        chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 6; i++) g_in[i] = 8'd0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) tick();
        rst_n = 1'b1;

        // Arming needs a disarm-then-arm edge.
        frame(8'hA5, 8'd0, 8'd10, 8'd0);
        chk("t1_first_frame_disarmed", 64'(link_state), 64'd1);
        chk("t1_first_frame_motor_off", 64'(motor_en), 64'd0);
        frame(8'hA5, 8'd0, 8'd10, 8'd0);
        chk("t1_no_edge", 64'(link_state), 64'd1);
        frame(8'h00, 8'd0, 8'd10, 8'd0);
        frame(8'hA5, 8'd0, 8'd10, 8'd0);
        chk("t1_armed", 64'(link_state), 64'd2);
        chk("t1_motor_en", 64'(motor_en), 64'd1);

        // Link loss while armed.
        repeat (TO - 1) tick();
        chk("t2_before_timeout", 64'(link_state), 64'd2);
        tick();
        chk("t2_failsafe_state", 64'(link_state), 64'd3);
        chk("t2_failsafe_flag", 64'(failsafe), 64'd1);
        chk("t2_motor_off", 64'(motor_en), 64'd0);
        repeat (24) tick();
        chk("t2_pitch_ramped_zero", 64'(set_pitch), 64'd0);
        frame(8'hA5, 8'd0, 8'd50, 8'd0);
        chk("t2_arm_ignored", 64'(link_state), 64'd3);
        frame(8'h00, 8'd0, 8'd50, 8'd0);
        chk("t2_disarmed", 64'(link_state), 64'd1);

        // Full-scale ramps without wrap.
        frame(8'h00, 8'd0, 8'h81, 8'h7F);
        repeat (270) tick();
        chk("t3_at_minus127", 64'(set_pitch), 64'h81);
        frame(8'h00, 8'd0, 8'h7F, 8'h80);
        repeat (516) tick();
        chk("t3_at_plus127", 64'(set_pitch), 64'h7F);
        chk("t3_yaw_at_minus128", 64'(set_yaw), 64'h80);
        frame(8'h00, 8'd0, 8'h80, 8'h00);
        repeat (520) tick();
        chk("t3_at_minus128", 64'(set_pitch), 64'h80);

        // Gain saturation and sample-aligned commit.
        g_in[0] = 8'd250; g_in[5] = 8'd7;
        frame(8'h00, 8'd0, 8'h80, 8'h00);
        repeat (3) tick();
        chk("t4_not_committed", 64'(pitch_kP), 64'd0);
        cs = 1'b1; tick();
        chk("t4_kP_saturated", 64'(pitch_kP), 64'd200);
        chk("t4_yaw_kD", 64'(yaw_kD), 64'd7);
        chk("t4_updated_pulse", 64'(gains_updated), 64'd1);
        tick();
        chk("t4_pulse_single", 64'(gains_updated), 64'd0);
        cs = 1'b1; tick();
        chk("t4_no_repeat_pulse", 64'(gains_updated), 64'd0);

        // MPU init edge detection.
        pulses = 0;
        frame(8'h00, 8'd0, 8'h80, 8'h00); pulses += int'(mpu_init_pulse);
        frame(8'h00, 8'd1, 8'h80, 8'h00); pulses += int'(mpu_init_pulse);
        frame(8'h00, 8'd1, 8'h80, 8'h00); pulses += int'(mpu_init_pulse);
        frame(8'h00, 8'd0, 8'h80, 8'h00); pulses += int'(mpu_init_pulse);
        frame(8'h00, 8'd3, 8'h80, 8'h00); pulses += int'(mpu_init_pulse);
        chk("t5_mpu_pulses", 64'(pulses), 64'd2);

        // Frame on the watchdog's final cycle wins.
        frame(8'hA5, 8'd0, 8'h80, 8'h00);
        chk("t5_rearmed", 64'(link_state), 64'd2);
        repeat (TO - 1) tick();
        frame(8'hA5, 8'd0, 8'h80, 8'h00);
        chk("t5_deadline_frame", 64'(link_state), 64'd2);
        repeat (5) tick();
        chk("t5_still_armed", 64'(link_state), 64'd2);

        // Asynchronous reset while armed and mid-ramp.
        frame(8'hA5, 8'd0, 8'd100, 8'd0);
        repeat (10) tick();
        chk("t6_armed_before_reset", 64'(motor_en), 64'd1);
        #3 rst_n = 1'b0;
        #1 check_all_zero("t6_async");
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;

        // Frame counter wrap.
        for (int i = 0; i < 65535; i++) begin
            motor_in = 8'h00; vv = 1'b1; tick();
        end
        chk("t6_count_ffff", 64'(frame_count), 64'hFFFF);
        frame(8'h00, 8'd0, 8'd0, 8'd0);
        chk("t6_count_wrap", 64'(frame_count), 64'd0);

        // Random traffic with alternating busy and silent stretches.
        for (int seg = 0; seg < 6; seg++) begin
            int len;
            len = $urandom_range(300, 1200);
            for (int c = 0; c < len; c++) begin
                if ((seg % 2) == 0 && ($urandom % 4) == 0) begin
                    case ($urandom % 3)
                        0: motor_in = 8'hA5;
                        1: motor_in = 8'h00;
                        default: motor_in = 8'($urandom);
                    endcase
                    mpu_in = 8'($urandom_range(0, 2));
                    sp_in  = 8'($urandom);
                    sy_in  = 8'($urandom);
                    for (int i = 0; i < 6; i++) g_in[i] = 8'($urandom);
                    vv = 1'b1;
                end
                cs = (($urandom % 6) == 0);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ble_link_supervisor.md
Name: ble_link_supervisor

Overview:
- Sits directly downstream of the BLE vector parser. Consumes its 10 decoded bytes and its one-cycle vector_valid strobe.
- Produces the values the balance/PID loop actually uses: ramped signed setpoints, gains clamped and committed on the control-sample boundary, a motor-arm state machine, an MPU-init pulse and a link-loss watchdog with failsafe.
- Isolates the control loop from raw, possibly stale or abrupt Bluetooth commands.

Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- TIMEOUT_MS, 500: link-loss timeout in milliseconds. TIMEOUT_CYCLES = (CLK_FREQ/1000)*TIMEOUT_MS.
- RAMP_DIV, 100_000: clock cycles per ramp tick.
- RAMP_STEP, 1: maximum setpoint change per ramp tick, in LSB.
- MAX_GAIN, 200: saturation ceiling for every gain byte.
- ARM_CODE, 8'hA5: motor byte value that requests arming.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vector_valid  in  1  one-cycle strobe; all byte inputs are valid this cycle
- initialize_mpu_motor  in  8  arm request byte
- initialize_mpu  in  8  MPU init request byte; nonzero = request
- ble_set_pitch  in  8  signed pitch setpoint target
- ble_set_yaw  in  8  signed yaw setpoint target
- ble_pitch_kP, ble_pitch_kI, ble_pitch_kD  in  8 each  pitch gains
- ble_yaw_kP, ble_yaw_kI, ble_yaw_kD  in  8 each  yaw gains
- ctrl_sample  in  1  one-cycle strobe from the PID loop marking a safe gain-update point
- set_pitch, set_yaw  out  8  signed ramped setpoints
- pitch_kP, pitch_kI, pitch_kD, yaw_kP, yaw_kI, yaw_kD  out  8 each  committed gains
- gains_updated  out  1  one-cycle pulse when committed gains change
- mpu_init_pulse  out  1  one-cycle MPU init request
- motor_en  out  1  motors allowed to drive
- link_state  out  2  0 NO_LINK, 1 DISARMED, 2 ARMED, 3 FAILSAFE
- failsafe  out  1  high while in FAILSAFE
- frame_count  out  16  accepted frames, wraps at 16'hFFFF -> 0

Behaviour:
Reset:
- Asynchronous on rst_n low. All outputs go to 0 and link_state is NO_LINK.
- Internal shadow gains, targets, watchdog counter, ramp divider, prev_arm and prev_mpu all clear to 0.
- Reset asserted mid-ramp or while ARMED drops motor_en the same instant, with no clock needed.

Watchdog:
- 32-bit counter. Clears on vector_valid, otherwise increments, saturating at TIMEOUT_CYCLES.
- The timeout event fires on the cycle the counter first reaches TIMEOUT_CYCLES.
- If vector_valid and reaching the limit occur in the same cycle, the frame wins: counter clears and no timeout fires.
- The watchdog runs in every state. In NO_LINK it has no effect.

State machine (registered; updates on the clock after vector_valid or timeout):
- NO_LINK:
  - Any frame -> DISARMED, even if the motor byte is ARM_CODE.
- DISARMED:
  - Frame with motor byte == ARM_CODE and prev_arm != ARM_CODE -> ARMED.
  - Timeout -> NO_LINK.
- ARMED:
  - Frame with motor byte != ARM_CODE -> DISARMED.
  - Timeout -> FAILSAFE.
- FAILSAFE:
  - Frame with motor byte != ARM_CODE -> DISARMED.
  - Frames carrying ARM_CODE refresh the watchdog but are otherwise ignored for arming.
  - Timeout holds FAILSAFE.
- prev_arm updates on every frame, so arming requires a disarm-then-arm edge seen by this block.
- motor_en = (link_state == ARMED), registered. failsafe = (link_state == FAILSAFE).

Frame handling (on vector_valid):
- frame_count increments.
- Shadow gains load with per-byte saturation: value > MAX_GAIN stores MAX_GAIN.
- Setpoint targets load from the frame in DISARMED/ARMED, and also in NO_LINK (the frame that causes the transition). In FAILSAFE, targets stay 0.
- Entering NO_LINK or FAILSAFE forces both targets to 0.
- mpu_init_pulse goes high the cycle after a frame where initialize_mpu != 0 and prev_mpu == 0. prev_mpu then updates to the frame value.

Gain commit:
- On ctrl_sample, if the shadow differs from the committed gains, copy all six gains in the same cycle and pulse gains_updated on the next cycle.
- If ctrl_sample and vector_valid coincide, the pre-frame shadow is committed. The new frame commits at the next ctrl_sample.
- Gains are never partially updated.

Setpoint ramp:
- A divider counts 0..RAMP_DIV-1. At terminal count it issues a tick and wraps.
- Per tick, each setpoint moves toward its target using signed compare:
  - If |target - current| <= RAMP_STEP, current = target.
  - Otherwise current changes by ±RAMP_STEP.
- Arithmetic is done in 9-bit signed to avoid overflow, e.g. -128 to +127 with no wrap.
- The ramp is active in all states.

Test Plan:
Use a bench with CLK_FREQ=1_000_000, TIMEOUT_MS=1 (1000 cycles), RAMP_DIV=4, RAMP_STEP=2.
1. Reset, then frame with motor=A5, set_pitch=10 -> link_state=DISARMED, motor_en=0. Next frame motor=A5 -> still DISARMED (no edge). Frame motor=00, then frame motor=A5 -> ARMED, motor_en=1.
2. In ARMED, send no frames for 1000 cycles -> FAILSAFE, motor_en=0, failsafe=1, set_pitch ramps to 0 by 2 per 4 cycles. Frame motor=A5 -> stays FAILSAFE. Frame motor=00 -> DISARMED.
3. Frame set_pitch=8'h7F from current set_pitch=8'h81 (-127) -> set_pitch increases by 2 per tick with no wrap and settles at exactly 127. Then target -128 -> settles at exactly -128.
4. Frame pitch_kP=250, yaw_kD=7 -> committed gains unchanged until ctrl_sample. On ctrl_sample, pitch_kP=200 and yaw_kD=7; gains_updated pulses once. A second ctrl_sample with no new frame produces no pulse.
5. Frames initialize_mpu = 0, 1, 1, 0, 3 -> mpu_init_pulse exactly twice (after the 1st "1" and after "3"). Also check vector_valid on the watchdog's final cycle -> no timeout.
6. Assert rst_n low asynchronously while ARMED and mid-ramp -> motor_en=0 and all outputs 0 before the next clk edge. frame_count=16'hFFFF plus one frame -> 0.
